// File: rtl/linebuf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : linebuf_pkg
//  Description : Shared types, default sizes and output field offsets for the
//                three-row feature-map line buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package linebuf_pkg;

    // Buffering phase: FILL while the first two rows of a frame load,
    // STREAM once every popped pixel has two rows above it.
    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Default geometry and the matching counter widths.
    localparam int DEF_DWIDTH = 32;
    localparam int DEF_IMG_W  = 32;
    localparam int DEF_IMG_H  = 32;
    localparam int COL_W      = $clog2(DEF_IMG_W);
    localparam int ROW_W      = $clog2(DEF_IMG_H);

    // Column word layout: {top = row r-2, mid = row r-1, bot = row r}.
    function automatic int bot_lsb(input int dw);
        return 0;
    endfunction

    function automatic int mid_lsb(input int dw);
        return dw;
    endfunction

    function automatic int top_lsb(input int dw);
        return 2 * dw;
    endfunction

endpackage : linebuf_pkg
`default_nettype wire

// File: rtl/linebuf_row_ram.sv
`default_nettype none
// ============================================================================
//  Module      : linebuf_row_ram
//  Description : One image row of storage. Single address, asynchronous
//                read and synchronous write, so a read in the same cycle as a
//                write returns the old contents (read-before-write).
//  Revision    : 1.0 - initial release
// ============================================================================
module linebuf_row_ram #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = 5
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    output logic [DWIDTH-1:0] rdata_o
);

    // Contents need no reset: every entry is rewritten before it is emitted.
    logic [DWIDTH-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    // Store the new pixel at the current column.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule : linebuf_row_ram
`default_nettype wire

// File: rtl/core_featuremap_linebuf3.sv
`default_nettype none
// ============================================================================
//  Module      : core_featuremap_linebuf3
//  Description : Raster pixel stream in, 3-row column words out. Two row
//                buffers hold rows r-1 and r-2; from row 2 onward each popped
//                pixel produces {row r-2, row r-1, row r} one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_featuremap_linebuf3 #(
    parameter int DWIDTH = 32,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DWIDTH-1:0]   ff_rdata,
    output logic                ff_rdreq,
    input  logic                ff_empty,
    output logic [3*DWIDTH-1:0] ff_wdata,
    output logic                ff_wrreq,
    input  logic                ff_full,
    output logic                frame_done
);
    import linebuf_pkg::*;

    localparam int COL_BITS = $clog2(IMG_W);
    localparam int ROW_BITS = $clog2(IMG_H);
    localparam int TOP_LSB  = top_lsb(DWIDTH);
    localparam int MID_LSB  = mid_lsb(DWIDTH);
    localparam int BOT_LSB  = bot_lsb(DWIDTH);

    state_e                state_q, state_d;
    logic [COL_BITS-1:0]   col_q, col_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic                  wrreq_q, wrreq_d;
    logic [3*DWIDTH-1:0]   wdata_q, wdata_d;
    logic                  done_q, done_d;

    logic                  pop;
    logic                  col_last;
    logic                  row_last;
    logic [DWIDTH-1:0]     lb0_rdata;
    logic [DWIDTH-1:0]     lb1_rdata;

    // Reset gates the pop so nothing leaves the input FIFO while held.
    assign pop      = reset & ~ff_empty & ~ff_full;
    assign ff_rdreq = pop;
    assign col_last = (col_q == COL_BITS'(IMG_W - 1));
    assign row_last = (row_q == ROW_BITS'(IMG_H - 1));

    // lb0 holds row r-1; its old value shifts down into lb1 (row r-2).
    linebuf_row_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (IMG_W),
        .AW     (COL_BITS)
    ) u_lb0 (
        .clock   (clock),
        .we_i    (pop),
        .addr_i  (col_q),
        .wdata_i (ff_rdata),
        .rdata_o (lb0_rdata)
    );

    linebuf_row_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (IMG_W),
        .AW     (COL_BITS)
    ) u_lb1 (
        .clock   (clock),
        .we_i    (pop),
        .addr_i  (col_q),
        .wdata_i (lb0_rdata),
        .rdata_o (lb1_rdata)
    );

    // Counter, phase and output-word next state; everything holds without a pop.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        wrreq_d = 1'b0;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        if (pop) begin
            col_d = col_last ? '0 : col_q + COL_BITS'(1);
            if (col_last) begin
                row_d = row_last ? '0 : row_q + ROW_BITS'(1);
            end
            case (state_q)
                FILL: begin
                    if (col_last && (row_q == ROW_BITS'(1))) begin
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    wrreq_d                        = 1'b1;
                    wdata_d[TOP_LSB +: DWIDTH]     = lb1_rdata;
                    wdata_d[MID_LSB +: DWIDTH]     = lb0_rdata;
                    wdata_d[BOT_LSB +: DWIDTH]     = ff_rdata;
                    if (col_last && row_last) begin
                        state_d = FILL;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
            wrreq_q <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            wrreq_q <= wrreq_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign ff_wrreq   = wrreq_q;
    assign ff_wdata   = wdata_q;
    assign frame_done = done_q;

endmodule : core_featuremap_linebuf3
`default_nettype wire

// File: tb/tb_core_featuremap_linebuf3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_featuremap_linebuf3
//  Description : Directed self-checking bench, 4x4 frames of 8-bit pixels.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_featuremap_linebuf3;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW-1:0]   ff_rdata = '0;
    logic            ff_rdreq;
    logic            ff_empty = 1'b1;
    logic [3*DW-1:0] ff_wdata;
    logic            ff_wrreq;
    logic            ff_full  = 1'b0;
    logic            frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3*DW-1:0] wq[$];
    bit              dq[$];
    int              wc[$];
    int              done_cnt   = 0;
    int              stray_done = 0;

    int              pop8_cyc;
    int              st_rd, st_wr_first, st_wr_later;
    logic [3*DW-1:0] st_word_first;

    core_featuremap_linebuf3 #(
        .DWIDTH (DW),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clock      (clk),
        .reset      (rst_n),
        .ff_rdata   (ff_rdata),
        .ff_rdreq   (ff_rdreq),
        .ff_empty   (ff_empty),
        .ff_wdata   (ff_wdata),
        .ff_wrreq   (ff_wrreq),
        .ff_full    (ff_full),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output FIFO model: record every written word away from the active edge.
    always @(negedge clk) begin
        if (rst_n && ff_wrreq) begin
            wq.push_back(ff_wdata);
            dq.push_back(frame_done);
            wc.push_back(cyc);
        end
        if (rst_n && frame_done) begin
            done_cnt++;
            if (!ff_wrreq) stray_done++;
        end
    end

    // Expected k-th output word of a frame whose first pixel value is base.
    function automatic logic [3*DW-1:0] exp_word(input int base, input int k);
        int p;
        logic [DW-1:0] a, b, c;
        p = base + 2*W + k;
        a = DW'(p - 2*W);
        b = DW'(p - W);
        c = DW'(p);
        return {a, b, c};
    endfunction

    task automatic clear_mon();
        @(negedge clk);
        #2;
        wq.delete();
        dq.delete();
        wc.delete();
        done_cnt   = 0;
        stray_done = 0;
    endtask

    // Source FIFO model. mode 0: no stall, 1: full for 5 cycles at pixel 10,
    // 2: empty every other cycle, 3: empty+full for 3 cycles at pixel 10.
    task automatic drive(input int base, input int n, input int mode);
        int  idx   = 0;
        int  stall = 0;
        int  guard = 0;
        int  slen;
        bit  alt   = 1'b0;
        bit  in_st;
        slen        = (mode == 1) ? 5 : 3;
        pop8_cyc    = -1;
        st_rd       = 0;
        st_wr_first = 0;
        st_wr_later = 0;
        st_word_first = '0;
        while (idx < n && guard < 1000) begin
            @(negedge clk);
            guard++;
            ff_rdata = DW'(base + idx);
            ff_empty = 1'b0;
            ff_full  = 1'b0;
            in_st    = 1'b0;
            if (mode == 2) begin
                ff_empty = alt;
                alt      = ~alt;
            end
            if ((mode == 1 || mode == 3) && idx == 10 && stall < slen) begin
                ff_full = 1'b1;
                if (mode == 3) ff_empty = 1'b1;
                in_st = 1'b1;
            end
            #1;
            if (in_st) begin
                if (ff_rdreq) st_rd++;
                if (stall == 0) begin
                    st_wr_first   = int'(ff_wrreq);
                    st_word_first = ff_wdata;
                end else if (ff_wrreq) begin
                    st_wr_later++;
                end
                stall++;
            end
            if (ff_rdreq) begin
                if (idx == 8) pop8_cyc = cyc;
                idx++;
            end
        end
        if (guard >= 1000) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: popped %0d of %0d pixels", idx, n);
        end
        @(negedge clk);
        ff_empty = 1'b1;
        ff_full  = 1'b0;
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        ff_empty = 1'b0;
        ff_full  = 1'b0;
        ff_rdata = 8'hAA;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ff_rdreq !== 1'b0) begin errors++; $display("FAIL reset_rdreq: got %b expected 0", ff_rdreq); end
        checks++; if (ff_wrreq !== 1'b0) begin errors++; $display("FAIL reset_wrreq: got %b expected 0", ff_wrreq); end
        checks++; if (ff_wdata !== '0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", ff_wdata); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", frame_done); end
        @(negedge clk);
        ff_empty = 1'b1;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [3*DW-1:0] first_w, last_w;
        first_w = {8'd0, 8'd4, 8'd8};
        last_w  = {8'd7, 8'd11, 8'd15};
        clear_mon();
        drive(0, 16, 0);
        checks++; if (wq.size() != 8) begin errors++; $display("FAIL basic_count: got %0d expected 8", wq.size()); end
        if (wq.size() == 8) begin
            checks++; if (wq[0] !== first_w) begin errors++; $display("FAIL basic_first: got %h expected %h", wq[0], first_w); end
            checks++; if (wq[7] !== last_w) begin errors++; $display("FAIL basic_last: got %h expected %h", wq[7], last_w); end
            checks++; if (wc[0] != pop8_cyc + 1) begin errors++; $display("FAIL basic_latency: write cycle %0d expected %0d", wc[0], pop8_cyc + 1); end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (wq[k] !== exp_word(0, k)) begin errors++; $display("FAIL basic_word[%0d]: got %h expected %h", k, wq[k], exp_word(0, k)); end
                checks++;
                if (dq[k] !== (k == 7)) begin errors++; $display("FAIL basic_done[%0d]: got %b expected %b", k, dq[k], (k == 7)); end
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (stray_done != 0) begin errors++; $display("FAIL basic_stray_done: got %0d expected 0", stray_done); end
    endtask

    task automatic test_back_to_back();
        logic [3*DW-1:0] e;
        clear_mon();
        drive(0, 32, 0);
        checks++; if (wq.size() != 16) begin errors++; $display("FAIL b2b_count: got %0d expected 16", wq.size()); end
        if (wq.size() == 16) begin
            for (int k = 0; k < 16; k++) begin
                e = (k < 8) ? exp_word(0, k) : exp_word(16, k - 8);
                checks++;
                if (wq[k] !== e) begin errors++; $display("FAIL b2b_word[%0d]: got %h expected %h", k, wq[k], e); end
            end
            checks++; if (wq[8] !== {8'd16, 8'd20, 8'd24}) begin errors++; $display("FAIL b2b_f2_first: got %h expected 101418", wq[8]); end
            checks++; if (dq[7] !== 1'b1 || dq[15] !== 1'b1) begin errors++; $display("FAIL b2b_done_pos: got %b/%b expected 1/1", dq[7], dq[15]); end
        end
        checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_cnt: got %0d expected 2", done_cnt); end
    endtask

    task automatic test_backpressure();
        clear_mon();
        drive(0, 16, 1);
        checks++; if (st_rd != 0) begin errors++; $display("FAIL bp_rdreq: got %0d pops expected 0", st_rd); end
        checks++; if (st_wr_first != 1 || st_word_first !== 24'h010509) begin errors++; $display("FAIL bp_inflight: got wr=%0d %h expected wr=1 010509", st_wr_first, st_word_first); end
        checks++; if (st_wr_later != 0) begin errors++; $display("FAIL bp_later_wr: got %0d expected 0", st_wr_later); end
        checks++; if (wq.size() != 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", wq.size()); end
        if (wq.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (wq[k] !== exp_word(0, k)) begin errors++; $display("FAIL bp_word[%0d]: got %h expected %h", k, wq[k], exp_word(0, k)); end
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_starve();
        clear_mon();
        drive(0, 16, 2);
        checks++; if (wq.size() != 8) begin errors++; $display("FAIL starve_count: got %0d expected 8", wq.size()); end
        if (wq.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (wq[k] !== exp_word(0, k)) begin errors++; $display("FAIL starve_word[%0d]: got %h expected %h", k, wq[k], exp_word(0, k)); end
            end
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (wc[k+1] - wc[k] != 2) begin errors++; $display("FAIL starve_gap[%0d]: got %0d expected 2", k, wc[k+1] - wc[k]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 10, 0);
        @(negedge clk);
        rst_n    = 1'b0;
        ff_empty = 1'b0;
        ff_full  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (ff_rdreq !== 1'b0 || ff_wrreq !== 1'b0 || ff_wdata !== '0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_outputs: got rd=%b wr=%b data=%h done=%b expected all 0", ff_rdreq, ff_wrreq, ff_wdata, frame_done);
            end
        end
        @(negedge clk);
        ff_empty = 1'b1;
        rst_n    = 1'b1;
        clear_mon();
        drive(0, 16, 0);
        checks++; if (wq.size() != 8) begin errors++; $display("FAIL rstmid_count: got %0d expected 8", wq.size()); end
        if (wq.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (wq[k] !== exp_word(0, k)) begin errors++; $display("FAIL rstmid_word[%0d]: got %h expected %h", k, wq[k], exp_word(0, k)); end
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rstmid_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_empty_full();
        clear_mon();
        drive(0, 16, 3);
        checks++; if (st_rd != 0) begin errors++; $display("FAIL ef_rdreq: got %0d pops expected 0", st_rd); end
        checks++; if (st_wr_first != 1 || st_word_first !== 24'h010509) begin errors++; $display("FAIL ef_pending: got wr=%0d %h expected wr=1 010509", st_wr_first, st_word_first); end
        checks++; if (st_wr_later != 0) begin errors++; $display("FAIL ef_later_wr: got %0d expected 0", st_wr_later); end
        checks++; if (wq.size() != 8) begin errors++; $display("FAIL ef_count: got %0d expected 8", wq.size()); end
        if (wq.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (wq[k] !== exp_word(0, k)) begin errors++; $display("FAIL ef_word[%0d]: got %h expected %h", k, wq[k], exp_word(0, k)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_starve();
        test_reset_mid();
        test_empty_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_core_featuremap_linebuf3
`default_nettype wire
